// File: rtl/alarm_clock_multi.sv
// 24-hour BCD clock with NUM_ALARMS enabled alarm slots and a ring/snooze/timeout FSM.
// Optional `ALARM_CLOCK_12H_EN adds mode_12h/pm and 12-hour display of the hour digits.
module alarm_clock_multi #(
   parameter int NUM_ALARMS     = 4,
   parameter int TICK_DIV       = 1,
   parameter int SNOOZE_S       = 300,
   parameter int RING_TIMEOUT_S = 60,
   localparam int AW            = $clog2(NUM_ALARMS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    in_hour_msb,
   input  logic [3:0]    in_hour_lsb,
   input  logic [3:0]    in_min_msb,
   input  logic [3:0]    in_min_lsb,
   input  logic          set_time,
   input  logic          set_alarm,
   input  logic [AW-1:0] alarm_sel,
   input  logic          en_wr,
   input  logic          en_val,
   input  logic          snooze,
   input  logic          alm_off,
`ifdef ALARM_CLOCK_12H_EN
   input  logic          mode_12h,
   output logic          pm,
`endif
   output logic [1:0]    hour_msb,
   output logic [3:0]    hour_lsb,
   output logic [3:0]    min_msb,
   output logic [3:0]    min_lsb,
   output logic [3:0]    sec_msb,
   output logic [3:0]    sec_lsb,
   output logic          alarm,
   output logic [AW-1:0] alarm_id,
   output logic          snoozed,
   output logic          set_err
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int RW = $clog2(RING_TIMEOUT_S + 1);
   localparam int SW = $clog2(SNOOZE_S + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RING = 2'd1;
   localparam logic [1:0] ST_SNZ  = 2'd2;

   function automatic logic set_valid(input logic [1:0] hm, input logic [3:0] hl,
                                      input logic [3:0] mm, input logic [3:0] ml);
      logic hour_ok;
      case (hm)
         2'd0, 2'd1: hour_ok = (hl <= 4'd9);
         2'd2:       hour_ok = (hl <= 4'd3);
         default:    hour_ok = 1'b0;
      endcase
      return hour_ok && (mm <= 4'd5) && (ml <= 4'd9);
   endfunction

   // {carry, next digit} for a BCD digit that wraps after max
   function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic [3:0] max);
      return (d >= max) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
   endfunction

   logic [PW-1:0] presc_r;
   logic          tick_s;
   logic          set_ok_s, set_time_ok_s, set_alarm_ok_s;
   logic [1:0]    h_msb_r, h_msb_t, h_msb_nx;
   logic [3:0]    h_lsb_r, h_lsb_t, h_lsb_nx;
   logic [3:0]    m_msb_r, m_msb_t, m_msb_nx;
   logic [3:0]    m_lsb_r, m_lsb_t, m_lsb_nx;
   logic [3:0]    s_msb_r, s_msb_t, s_msb_nx;
   logic [3:0]    s_lsb_r, s_lsb_t, s_lsb_nx;
   logic          c_s0_s, c_s1_s, c_m0_s, c_m1_s, day_end_s;
   logic [13:0]   in_hm_s, cur_hm_s;
   logic [13:0]   slot_r [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] en_r;
   logic          eval_r, hit_s;
   logic [AW-1:0] hit_id_s;
   logic [1:0]    state_r, state_n;
   logic [RW-1:0] ring_cnt_r, ring_cnt_n;
   logic [SW-1:0] snz_cnt_r, snz_cnt_n;
   logic [AW-1:0] id_r, id_n;
   logic          alarm_r, snoozed_r, set_err_r;

   assign tick_s         = (presc_r == PW'(TICK_DIV - 1));
   assign set_ok_s       = set_valid(in_hour_msb, in_hour_lsb, in_min_msb, in_min_lsb);
   assign set_time_ok_s  = set_time & set_ok_s;
   assign set_alarm_ok_s = set_alarm & set_ok_s;
   assign in_hm_s        = {in_hour_msb, in_hour_lsb, in_min_msb, in_min_lsb};
   assign cur_hm_s       = {h_msb_r, h_lsb_r, m_msb_r, m_lsb_r};

   // prescaler: one tick every TICK_DIV cycles, restarted by a valid set_time
   always_ff @(posedge clk) begin
      if (!reset) begin
         presc_r <= PW'(0);
      end else if (set_time_ok_s || tick_s) begin
         presc_r <= PW'(0);
      end else begin
         presc_r <= presc_r + PW'(1);
      end
   end

   // ripple-carry BCD increment chain
   assign {c_s0_s, s_lsb_t} = bcd_inc(s_lsb_r, 4'd9);
   assign {c_s1_s, s_msb_t} = c_s0_s ? bcd_inc(s_msb_r, 4'd5) : {1'b0, s_msb_r};
   assign {c_m0_s, m_lsb_t} = c_s1_s ? bcd_inc(m_lsb_r, 4'd9) : {1'b0, m_lsb_r};
   assign {c_m1_s, m_msb_t} = c_m0_s ? bcd_inc(m_msb_r, 4'd5) : {1'b0, m_msb_r};
   assign day_end_s = (h_msb_r == 2'd2) && (h_lsb_r == 4'd3);
   assign h_lsb_t = !c_m1_s ? h_lsb_r :
                    (day_end_s || (h_lsb_r == 4'd9)) ? 4'd0 : h_lsb_r + 4'd1;
   assign h_msb_t = !c_m1_s ? h_msb_r : day_end_s ? 2'd0 :
                    (h_lsb_r == 4'd9) ? h_msb_r + 2'd1 : h_msb_r;

   assign h_msb_nx = set_time_ok_s ? in_hour_msb : tick_s ? h_msb_t : h_msb_r;
   assign h_lsb_nx = set_time_ok_s ? in_hour_lsb : tick_s ? h_lsb_t : h_lsb_r;
   assign m_msb_nx = set_time_ok_s ? in_min_msb  : tick_s ? m_msb_t : m_msb_r;
   assign m_lsb_nx = set_time_ok_s ? in_min_lsb  : tick_s ? m_lsb_t : m_lsb_r;
   assign s_msb_nx = set_time_ok_s ? 4'd0        : tick_s ? s_msb_t : s_msb_r;
   assign s_lsb_nx = set_time_ok_s ? 4'd0        : tick_s ? s_lsb_t : s_lsb_r;

   // time-of-day registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         h_msb_r <= 2'd0; h_lsb_r <= 4'd0; m_msb_r <= 4'd0;
         m_lsb_r <= 4'd0; s_msb_r <= 4'd0; s_lsb_r <= 4'd0;
      end else begin
         h_msb_r <= h_msb_nx; h_lsb_r <= h_lsb_nx; m_msb_r <= m_msb_nx;
         m_lsb_r <= m_lsb_nx; s_msb_r <= s_msb_nx; s_lsb_r <= s_lsb_nx;
      end
   end

   // alarm slot storage; en_wr overrides the implicit enable of set_alarm
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_ALARMS; i++) slot_r[i] <= 14'd0;
         en_r <= {NUM_ALARMS{1'b0}};
      end else begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (set_alarm_ok_s && (alarm_sel == AW'(i))) slot_r[i] <= in_hm_s;
            if (en_wr && (alarm_sel == AW'(i))) begin
               en_r[i] <= en_val;
            end else if (set_alarm_ok_s && (alarm_sel == AW'(i))) begin
               en_r[i] <= 1'b1;
            end
         end
      end
   end

   // match is only evaluated in the cycle after a genuine tick, never after set_time
   always_ff @(posedge clk) begin
      if (!reset) begin
         eval_r <= 1'b0;
      end else begin
         eval_r <= tick_s & ~set_time_ok_s;
      end
   end

   // lowest-index enabled slot equal to hh:mm:00 wins
   always_comb begin
      hit_s    = 1'b0;
      hit_id_s = AW'(0);
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (eval_r && en_r[i] && (slot_r[i] == cur_hm_s) &&
             (s_msb_r == 4'd0) && (s_lsb_r == 4'd0)) begin
            hit_s    = 1'b1;
            hit_id_s = AW'(i);
         end else begin
            hit_s    = hit_s;
            hit_id_s = hit_id_s;
         end
      end
   end

   // ringer next-state logic
   always_comb begin
      state_n    = state_r;
      ring_cnt_n = ring_cnt_r;
      snz_cnt_n  = snz_cnt_r;
      id_n       = id_r;
      case (state_r)
         ST_IDLE: begin
            if (hit_s) begin
               state_n = ST_RING; id_n = hit_id_s; ring_cnt_n = RW'(0);
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_RING: begin
            if (alm_off) begin
               state_n = ST_IDLE;
            end else if (snooze) begin
               state_n = ST_SNZ; snz_cnt_n = SW'(SNOOZE_S);
            end else if (tick_s) begin
               if (ring_cnt_r == RW'(RING_TIMEOUT_S - 1)) begin
                  state_n = ST_IDLE;
               end else begin
                  ring_cnt_n = ring_cnt_r + RW'(1);
               end
            end else begin
               state_n = ST_RING;
            end
         end
         ST_SNZ: begin
            if (alm_off) begin
               state_n = ST_IDLE;
            end else if (hit_s) begin
               state_n = ST_RING; id_n = hit_id_s; ring_cnt_n = RW'(0);
            end else if (tick_s) begin
               if (snz_cnt_r == SW'(1)) begin
                  state_n = ST_RING; ring_cnt_n = RW'(0);
               end else begin
                  snz_cnt_n = snz_cnt_r - SW'(1);
               end
            end else begin
               state_n = ST_SNZ;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // ringer state and registered status outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         ring_cnt_r <= RW'(0);
         snz_cnt_r <= SW'(0);
         id_r      <= AW'(0);
         alarm_r   <= 1'b0;
         snoozed_r <= 1'b0;
         set_err_r <= 1'b0;
      end else begin
         state_r   <= state_n;
         ring_cnt_r <= ring_cnt_n;
         snz_cnt_r <= snz_cnt_n;
         id_r      <= id_n;
         alarm_r   <= (state_n == ST_RING);
         snoozed_r <= (state_n == ST_SNZ);
         set_err_r <= (set_time | set_alarm) & ~set_ok_s;
      end
   end

   assign alarm    = alarm_r;
   assign snoozed  = snoozed_r;
   assign alarm_id = id_r;
   assign set_err  = set_err_r;
   assign min_msb  = m_msb_r;
   assign min_lsb  = m_lsb_r;
   assign sec_msb  = s_msb_r;
   assign sec_lsb  = s_lsb_r;

`ifdef ALARM_CLOCK_12H_EN
   function automatic logic [5:0] hour_disp(input logic [1:0] hm, input logic [3:0] hl,
                                            input logic m12);
      logic [4:0] h24, h12;
      h24 = 5'(hm) * 5'd10 + 5'(hl);
      h12 = (h24 == 5'd0) ? 5'd12 : (h24 > 5'd12) ? h24 - 5'd12 : h24;
      if (!m12) begin
         return {hm, hl};
      end else begin
         return (h12 >= 5'd10) ? {2'd1, 4'(h12 - 5'd10)} : {2'd0, 4'(h12)};
      end
   endfunction

   logic [5:0] disp_hour_r;
   logic       pm_r;

   // display hour re-encoded from the next-state hour so it stays aligned with the minutes
   always_ff @(posedge clk) begin
      if (!reset) begin
         disp_hour_r <= 6'd0;
         pm_r        <= 1'b0;
      end else begin
         disp_hour_r <= hour_disp(h_msb_nx, h_lsb_nx, mode_12h);
         pm_r        <= (h_msb_nx == 2'd2) || ((h_msb_nx == 2'd1) && (h_lsb_nx >= 4'd2));
      end
   end

   assign hour_msb = disp_hour_r[5:4];
   assign hour_lsb = disp_hour_r[3:0];
   assign pm       = pm_r;
`else
   assign hour_msb = h_msb_r;
   assign hour_lsb = h_lsb_r;
`endif

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed self-checking bench for alarm_clock_multi (default parameters, TICK_DIV=1).
module tb_alarm_clock_multi;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [1:0]    in_hour_msb = 2'd0;
   logic [3:0]    in_hour_lsb = 4'd0, in_min_msb = 4'd0, in_min_lsb = 4'd0;
   logic          set_time = 1'b0, set_alarm = 1'b0, en_wr = 1'b0, en_val = 1'b0;
   logic [AW-1:0] alarm_sel = 2'd0;
   logic          snooze = 1'b0, alm_off = 1'b0;
   logic [1:0]    hour_msb;
   logic [3:0]    hour_lsb, min_msb, min_lsb, sec_msb, sec_lsb;
   logic          alarm, snoozed, set_err;
   logic [AW-1:0] alarm_id;
   logic [23:0]   cur_time;
`ifdef ALARM_CLOCK_12H_EN
   logic          mode_12h = 1'b0;
   logic          pm;
`endif

   always #5 clk = ~clk;

   alarm_clock_multi dut (
      .clk(clk), .reset(reset),
      .in_hour_msb(in_hour_msb), .in_hour_lsb(in_hour_lsb),
      .in_min_msb(in_min_msb), .in_min_lsb(in_min_lsb),
      .set_time(set_time), .set_alarm(set_alarm), .alarm_sel(alarm_sel),
      .en_wr(en_wr), .en_val(en_val), .snooze(snooze), .alm_off(alm_off),
`ifdef ALARM_CLOCK_12H_EN
      .mode_12h(mode_12h), .pm(pm),
`endif
      .hour_msb(hour_msb), .hour_lsb(hour_lsb), .min_msb(min_msb), .min_lsb(min_lsb),
      .sec_msb(sec_msb), .sec_lsb(sec_lsb), .alarm(alarm), .alarm_id(alarm_id),
      .snoozed(snoozed), .set_err(set_err)
   );

   assign cur_time = {2'b00, hour_msb, hour_lsb, min_msb, min_lsb, sec_msb, sec_lsb};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_hm(input logic [1:0] hm, input logic [3:0] hl,
                           input logic [3:0] mm, input logic [3:0] ml);
      in_hour_msb = hm; in_hour_lsb = hl; in_min_msb = mm; in_min_lsb = ml;
   endtask

   task automatic do_set_time(input logic [1:0] hm, input logic [3:0] hl,
                              input logic [3:0] mm, input logic [3:0] ml);
      drive_hm(hm, hl, mm, ml);
      set_time = 1'b1;
      cyc(1);
      set_time = 1'b0;
   endtask

   task automatic do_set_alarm(input logic [1:0] sel, input logic [1:0] hm, input logic [3:0] hl,
                               input logic [3:0] mm, input logic [3:0] ml);
      drive_hm(hm, hl, mm, ml);
      alarm_sel = sel;
      set_alarm = 1'b1;
      cyc(1);
      set_alarm = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  hm;
      logic [3:0]  hl;
      logic [3:0]  mm;
      logic [3:0]  ml;
      logic        err;
      logic [23:0] t;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{2'd1, 4'd2,  4'd3, 4'd4,  1'b0, 24'h123400};
      vecs[1] = '{2'd2, 4'd4,  4'd0, 4'd0,  1'b1, 24'h123401};
      vecs[2] = '{2'd0, 4'd5,  4'd6, 4'd0,  1'b1, 24'h123402};
      vecs[3] = '{2'd0, 4'd9,  4'd5, 4'd10, 1'b1, 24'h123403};
      vecs[4] = '{2'd1, 4'd10, 4'd0, 4'd0,  1'b1, 24'h123404};
      vecs[5] = '{2'd2, 4'd3,  4'd5, 4'd9,  1'b0, 24'h235900};
      vecs[6] = '{2'd3, 4'd0,  4'd0, 4'd0,  1'b1, 24'h235901};
      vecs[7] = '{2'd0, 4'd0,  4'd0, 4'd0,  1'b0, 24'h000000};
      vecs[8] = '{2'd1, 4'd9,  4'd0, 4'd9,  1'b0, 24'h190900};
      vecs[9] = '{2'd2, 4'd0,  4'd4, 4'd5,  1'b0, 24'h204500};

      // reset state and first ticks
      cyc(2);
      check("rst_time", cur_time, 24'h000000);
      check("rst_alarm", alarm, 1'b0);
      check("rst_snoozed", snoozed, 1'b0);
      check("rst_id", alarm_id, 2'd0);
      check("rst_err", set_err, 1'b0);
      reset = 1'b1;
      cyc(3);
      check("run3_time", cur_time, 24'h000003);
      check("run3_alarm", alarm, 1'b0);

      // midnight rollover
      do_set_time(2'd2, 4'd3, 4'd5, 4'd9);
      check("set_2359", cur_time, 24'h235900);
      cyc(59);
      check("t_235959", cur_time, 24'h235959);
      cyc(1);
      check("rollover", cur_time, 24'h000000);
      check("rollover_id", alarm_id, 2'd0);

      // set validation table (every cycle also carries a tick)
      for (int i = 0; i < 10; i++) begin
         drive_hm(vecs[i].hm, vecs[i].hl, vecs[i].mm, vecs[i].ml);
         set_time = 1'b1;
         cyc(1);
         check($sformatf("vec%0d_time", i), cur_time, vecs[i].t);
         check($sformatf("vec%0d_err", i), set_err, vecs[i].err);
      end
      set_time = 1'b0;
      cyc(1);
      check("err_pulse_end", set_err, 1'b0);
      check("after_tbl_time", cur_time, 24'h204501);
      do_set_alarm(2'd1, 2'd0, 4'd7, 4'd6, 4'd0);
      check("bad_alarm_err", set_err, 1'b1);
      check("bad_alarm_time", cur_time, 24'h204502);

      // two slots at 07:30: lowest index reports
      do_set_alarm(2'd2, 2'd0, 4'd7, 4'd3, 4'd0);
      check("slot2_err", set_err, 1'b0);
      do_set_alarm(2'd0, 2'd0, 4'd7, 4'd3, 4'd0);
      do_set_time(2'd0, 4'd7, 4'd2, 4'd9);
      check("set_0729", cur_time, 24'h072900);
      cyc(60);
      check("show_0730", cur_time, 24'h073000);
      check("no_alarm_yet", alarm, 1'b0);
      cyc(1);
      check("alarm_rise", alarm, 1'b1);
      check("alarm_id0", alarm_id, 2'd0);
      en_wr = 1'b1; alarm_sel = 2'd0; en_val = 1'b0;
      cyc(1);
      en_wr = 1'b0;
      check("disable_keeps_ring", alarm, 1'b1);
      cyc(58);
      check("ring_before_timeout", alarm, 1'b1);
      cyc(1);
      check("ring_timeout", alarm, 1'b0);

      // slot 0 now disabled: slot 2 rings; snooze and re-ring
      do_set_time(2'd0, 4'd7, 4'd2, 4'd9);
      cyc(61);
      check("ring2", alarm, 1'b1);
      check("alarm_id2", alarm_id, 2'd2);
      snooze = 1'b1;
      cyc(1);
      snooze = 1'b0;
      check("snz_state", snoozed, 1'b1);
      check("snz_alarm", alarm, 1'b0);
      cyc(299);
      check("snz_still", snoozed, 1'b1);
      check("snz_quiet", alarm, 1'b0);
      cyc(1);
      check("rering", alarm, 1'b1);
      check("rering_snz", snoozed, 1'b0);
      check("rering_id", alarm_id, 2'd2);
      snooze = 1'b1; alm_off = 1'b1;
      cyc(1);
      snooze = 1'b0; alm_off = 1'b0;
      check("off_alarm", alarm, 1'b0);
      check("off_snz", snoozed, 1'b0);
      check("off_id_kept", alarm_id, 2'd2);

      // reset while ringing
      do_set_time(2'd0, 4'd7, 4'd2, 4'd9);
      cyc(61);
      check("ring_pre_rst", alarm, 1'b1);
      reset = 1'b0;
      cyc(1);
      check("midrst_alarm", alarm, 1'b0);
      check("midrst_time", cur_time, 24'h000000);
      check("midrst_id", alarm_id, 2'd0);
      reset = 1'b1;

`ifdef ALARM_CLOCK_12H_EN
      mode_12h = 1'b1;
      do_set_time(2'd0, 4'd0, 4'd1, 4'd5);
      check("h12_midnight", {hour_msb, hour_lsb}, {2'd1, 4'd2});
      check("h12_am", pm, 1'b0);
      do_set_time(2'd1, 4'd3, 4'd0, 4'd5);
      check("h12_1pm", {hour_msb, hour_lsb}, {2'd0, 4'd1});
      check("h12_pm", pm, 1'b1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
